field_assembler: RTL and testbench
==================================

FIELD_ASSEMBLER -- requirements
Module: field_assembler

Interface
REQ-001 Parameter NUM_FIELDS, default 2: number of fields per packed record, legal range 1..16.
REQ-002 Parameter FIELD_W, default 2: width of each field in bits, legal range 1..32.
REQ-003 Port clk, input, 1: single clock, all state on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port clear, input, 1: synchronous discard of a partially collected record.
REQ-006 Port field_data, input, NUM_FIELDS*FIELD_W: field i occupies bits [i*FIELD_W +: FIELD_W].
REQ-007 Port field_valid, input, NUM_FIELDS: bit i qualifies field i.
REQ-008 Port field_ready, output, NUM_FIELDS: bit i means field i is accepted this cycle if valid.
REQ-009 Port out_data, output, NUM_FIELDS*FIELD_W: assembled record, field i at bits [i*FIELD_W +: FIELD_W], so field 0 is the least significant.
REQ-010 Port out_valid, output, 1: record complete and presented.
REQ-011 Port out_ready, input, 1: downstream accepts the record.
REQ-012 Port record_count, output, 16: number of records delivered, wraps modulo 2^16.

Function
REQ-013 Per-field flag captured[i] SHALL be held; field i is accepted when field_valid[i] & field_ready[i].
REQ-014 On acceptance, field i data SHALL be stored in its slot and captured[i] set on the same edge.
REQ-015 Fields SHALL be accepted in any order and any combination per cycle; the slots of unaccepted fields are unchanged.
REQ-016 out_valid SHALL be registered: high the cycle after the final missing field is accepted, i.e. one-cycle latency from the last field to the record.
REQ-017 The block has two states. COLLECT: out_valid=0, with at least one field not yet captured. HOLD: out_valid=1, all fields captured. COLLECT->HOLD when all flags become set. HOLD->COLLECT on out_valid & out_ready, unless every field is re-accepted in that cycle, in which case the state stays HOLD.
REQ-018 field_ready[i] SHALL equal ~captured[i] | (out_valid & out_ready); this is a combinational path from out_ready.
REQ-019 On an output handshake, captured[i] SHALL be set exactly for the fields accepted in that cycle; all other flags clear. This gives back-to-back records at one record per cycle.
REQ-020 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable and field_ready SHALL be 0.
REQ-021 record_count SHALL increment by 1 on each output handshake and wrap from 16'hFFFF to 0.
REQ-022 clear=1 SHALL clear all captured flags and force COLLECT, and SHALL discard fields presented in that cycle.
REQ-023 If clear and an output handshake occur in the same cycle, the handshake SHALL complete and be counted, and clear then applies.
REQ-024 clear SHALL NOT alter slot data, out_data or record_count.
REQ-025 With NUM_FIELDS=1, every accepted field SHALL produce a record with one-cycle latency.

Reset
REQ-026 While rst=1: captured=0, slot storage and out_data=0, out_valid=0, record_count=0, and state is COLLECT.
REQ-027 rst SHALL take effect immediately regardless of clk and abort any partial or held record. The first acceptance is the first rising edge after rst deasserts.

Verification (NUM_FIELDS=2, FIELD_W=2)
REQ-028 Scenario 1: field 1=2'b10 valid in cycle 0, field 0=2'b01 valid in cycle 2, out_ready=1 -> out_valid=1 in cycle 3 with out_data=4'b1001, and record_count=1 after the handshake.
REQ-029 Scenario 2: both fields valid each cycle with values 3,0 then 1,2, out_ready=1 -> out_data=4'b0011 then 4'b1001 on consecutive cycles, with no gap.
REQ-030 Scenario 3: record held with out_ready=0 for 5 cycles while field_valid=2'b11 -> field_ready=2'b00, and out_data stays stable; raising out_ready -> handshake with simultaneous capture of the next record.
REQ-031 Scenario 4: field 0 captured, then clear=1 -> field_ready=2'b11 next cycle; the next record has no stale field 0 and requires both fields.
REQ-032 Scenario 5: record_count preset by 65535 handshakes, then one more handshake -> record_count=0.
REQ-033 Scenario 6: rst pulsed asynchronously mid-HOLD (between clock edges) -> out_valid, out_data and record_count are 0 immediately, with no handshake counted.

Source files
------------

// File: rtl/field_assembler.sv
// Collects NUM_FIELDS independently handshaked fields into one packed record and
// presents it with a registered valid/ready handshake.
module field_assembler #(
    parameter int NUM_FIELDS = 2,
    parameter int FIELD_W    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic [NUM_FIELDS*FIELD_W-1:0] field_data,
    input  logic [NUM_FIELDS-1:0]         field_valid,
    output logic [NUM_FIELDS-1:0]         field_ready,
    output logic [NUM_FIELDS*FIELD_W-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   record_count
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e                          state_q, state_d;
    logic [NUM_FIELDS-1:0]           captured_q, captured_d;
    logic [NUM_FIELDS*FIELD_W-1:0]   slots_q, slots_d;
    logic [15:0]                     count_q, count_d;
    logic [NUM_FIELDS-1:0]           accept;
    logic                            handshake;

    // The record leaves in the same cycle new fields arrive, so ready is
    // reopened combinationally by out_ready to sustain one record per cycle.
    assign handshake   = out_valid & out_ready;
    assign field_ready = ~captured_q | {NUM_FIELDS{handshake}};
    assign accept      = field_valid & field_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: begin
                if (!clear && (&captured_d)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (clear || (handshake && !(&captured_d))) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Output decode
    always_comb begin
        out_valid = (state_q == HOLD);
    end

    // Capture flags, slot storage and the delivered-record counter
    always_comb begin
        captured_d = handshake ? '0 : captured_q;
        slots_d    = slots_q;
        count_d    = count_q;
        if (handshake) begin
            count_d = count_q + 16'd1;
        end
        if (clear) begin
            captured_d = '0;
        end else begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (accept[i]) begin
                    slots_d[i*FIELD_W +: FIELD_W] = field_data[i*FIELD_W +: FIELD_W];
                    captured_d[i]                 = 1'b1;
                end
            end
        end
    end

    // NOTE: slot storage is reset too, so out_data reads as zero during and after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            captured_q <= '0;
            slots_q    <= '0;
            count_q    <= '0;
        end else begin
            captured_q <= captured_d;
            slots_q    <= slots_d;
            count_q    <= count_d;
        end
    end

    assign out_data     = slots_q;
    assign record_count = count_q;

endmodule

// File: tb/tb_field_assembler.sv
// Randomized and directed checks of field_assembler against a record-level
// reference model held in the bench.
module tb_field_assembler;

    localparam int NF = 2;
    localparam int W  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic [NF*W-1:0]   field_data = '0;
    logic [NF-1:0]     field_valid = '0;
    logic [NF-1:0]     field_ready;
    logic [NF*W-1:0]   out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [15:0]       record_count;

    int errors = 0;
    int checks = 0;

    // Reference model: which fields of the pending record are held, their
    // values, whether a complete record is on offer, and records delivered.
    logic [W-1:0]  m_slot [NF];
    bit            m_have [NF];
    bit            m_hold;
    logic [15:0]   m_count;

    field_assembler #(.NUM_FIELDS(NF), .FIELD_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .field_data   (field_data),
        .field_valid  (field_valid),
        .field_ready  (field_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .record_count (record_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin
            m_slot[i] = '0;
            m_have[i] = 1'b0;
        end
        m_hold  = 1'b0;
        m_count = '0;
    endtask

    // A field may enter if its slot is empty or the held record is leaving now.
    function automatic logic [NF-1:0] m_ready();
        logic [NF-1:0] r;
        for (int i = 0; i < NF; i++) begin
            r[i] = !m_have[i] || (m_hold && out_ready);
        end
        return r;
    endfunction

    function automatic logic [NF*W-1:0] m_record();
        logic [NF*W-1:0] r;
        for (int i = 0; i < NF; i++) begin
            r[i*W +: W] = m_slot[i];
        end
        return r;
    endfunction

    task automatic model_update();
        logic [NF-1:0] rdy;
        bit            all_have;
        bit            hs;
        rdy = m_ready();
        hs  = m_hold && out_ready;
        if (hs) m_count = m_count + 16'd1;
        if (clear) begin
            for (int i = 0; i < NF; i++) m_have[i] = 1'b0;
            m_hold = 1'b0;
        end else begin
            if (hs) for (int i = 0; i < NF; i++) m_have[i] = 1'b0;
            for (int i = 0; i < NF; i++) begin
                if (field_valid[i] && rdy[i]) begin
                    m_slot[i] = field_data[i*W +: W];
                    m_have[i] = 1'b1;
                end
            end
            all_have = 1'b1;
            for (int i = 0; i < NF; i++) all_have = all_have && m_have[i];
            m_hold = all_have;
        end
    endtask

    task automatic drive(input logic [NF-1:0] v, input logic [NF*W-1:0] d,
                         input logic ordy, input logic clr);
        field_valid = v;
        field_data  = d;
        out_ready   = ordy;
        clear       = clr;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        drive('0, '0, 1'b0, 1'b0);
        #3;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_data got=%b exp=0", out_data); end
        checks++;
        if (record_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", record_count); end
        checks++;
        if (field_ready !== 2'b11) begin errors++; $display("FAIL reset_ready got=%b exp=11", field_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_scenario1();
        drive(2'b10, 4'b1000, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (field_ready !== m_ready()) begin errors++; $display("FAIL s1_ready got=%b exp=%b", field_ready, m_ready()); end
        step();
        drive(2'b00, 4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL s1_early_valid got=%b exp=0", out_valid); end
        step();
        drive(2'b01, 4'b0001, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL s1_c2_valid got=%b exp=0", out_valid); end
        step();
        drive(2'b00, 4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1001) begin
            errors++; $display("FAIL s1_record got=%b/%b exp=1/1001", out_valid, out_data);
        end
        step();
        @(negedge clk);
        checks++;
        if (record_count !== 16'd1) begin errors++; $display("FAIL s1_count got=%0d exp=1", record_count); end
    endtask

    task automatic test_back_to_back();
        drive(2'b11, 4'b0011, 1'b1, 1'b0);
        step();
        drive(2'b11, 4'b1001, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b0011) begin
            errors++; $display("FAIL b2b_first got=%b/%b exp=1/0011", out_valid, out_data);
        end
        step();
        drive(2'b00, 4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1001) begin
            errors++; $display("FAIL b2b_second got=%b/%b exp=1/1001", out_valid, out_data);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || record_count !== m_count) begin
            errors++; $display("FAIL b2b_drain got=%b/%0d exp=0/%0d", out_valid, record_count, m_count);
        end
    endtask

    task automatic test_backpressure();
        logic [NF*W-1:0] held;
        logic [NF*W-1:0] next;
        held = (NF*W)'($urandom);
        next = ~held;
        drive(2'b11, held, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(2'b11, (NF*W)'($urandom), 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (field_ready !== 2'b00 || out_valid !== 1'b1 || out_data !== held) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got=%b/%b/%b exp=00/1/%b", k, field_ready, out_valid, out_data, held);
            end
            step();
        end
        drive(2'b11, next, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (field_ready !== 2'b11 || out_data !== held) begin
            errors++; $display("FAIL bp_release got=%b/%b exp=11/%b", field_ready, out_data, held);
        end
        step();
        drive(2'b00, '0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== next || record_count !== m_count) begin
            errors++;
            $display("FAIL bp_next got=%b/%b/%0d exp=1/%b/%0d", out_valid, out_data, record_count, next, m_count);
        end
        step();
    endtask

    task automatic test_clear();
        logic [NF*W-1:0] rec;
        drive(2'b01, 4'b0010, 1'b1, 1'b0);
        step();
        drive(2'b00, '0, 1'b1, 1'b1);
        step();
        drive(2'b00, '0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (field_ready !== 2'b11) begin errors++; $display("FAIL clr_ready got=%b exp=11", field_ready); end
        drive(2'b10, 4'b0100, 1'b1, 1'b0);
        step();
        drive(2'b00, '0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_stale got=%b exp=0", out_valid); end
        step();
        drive(2'b01, 4'b0011, 1'b1, 1'b0);
        step();
        drive(2'b00, '0, 1'b1, 1'b0);
        rec = 4'b0111;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== rec) begin
            errors++; $display("FAIL clr_record got=%b/%b exp=1/%b", out_valid, out_data, rec);
        end
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(NF'($urandom), (NF*W)'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0);
            @(negedge clk);
            checks++;
            if (field_ready !== m_ready()) begin
                errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", k, field_ready, m_ready());
            end
            checks++;
            if (out_valid !== m_hold) begin
                errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", k, out_valid, m_hold);
            end
            if (m_hold) begin
                checks++;
                if (out_data !== m_record()) begin
                    errors++; $display("FAIL rnd_data cyc=%0d got=%b exp=%b", k, out_data, m_record());
                end
            end
            checks++;
            if (record_count !== m_count) begin
                errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", k, record_count, m_count);
            end
            step();
        end
        drive(2'b00, '0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_async_reset();
        drive(2'b11, 4'b1110, 1'b0, 1'b0);
        step();
        drive(2'b00, '0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || record_count !== 16'd0) begin
            errors++;
            $display("FAIL arst got=%b/%b/%0d exp=0/0/0", out_valid, out_data, record_count);
        end
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (record_count !== 16'd0) begin errors++; $display("FAIL arst_held got=%0d exp=0", record_count); end
        @(negedge clk);
        rst = 1'b0;
        drive(2'b00, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 65536; k++) begin
            drive(2'b11, (NF*W)'($urandom), 1'b1, 1'b0);
            step();
        end
        drive(2'b00, '0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (record_count !== 16'hFFFF || m_count !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_pre got=%0d exp=65535", record_count);
        end
        step();
        @(negedge clk);
        checks++;
        if (record_count !== 16'd0) begin errors++; $display("FAIL wrap got=%0d exp=0", record_count); end
    endtask

    initial begin
        test_reset();
        test_scenario1();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_random();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
